// File: rtl/ps2_keystroke_tx_pkg.sv
// Shared definitions for the PS/2 keystroke transmitter: letter codes (common
// with the receive-side decoder), scan-code make bytes, break prefix, FSM
// states and the frame-bit selector.
package ps2_keystroke_tx_pkg;

  // Letter codes, a=0 .. z=25, plus ENTR and the decoder's OTHER code
  localparam logic [4:0] KEY_A     = 5'd0;
  localparam logic [4:0] KEY_B     = 5'd1;
  localparam logic [4:0] KEY_C     = 5'd2;
  localparam logic [4:0] KEY_D     = 5'd3;
  localparam logic [4:0] KEY_E     = 5'd4;
  localparam logic [4:0] KEY_F     = 5'd5;
  localparam logic [4:0] KEY_G     = 5'd6;
  localparam logic [4:0] KEY_H     = 5'd7;
  localparam logic [4:0] KEY_I     = 5'd8;
  localparam logic [4:0] KEY_J     = 5'd9;
  localparam logic [4:0] KEY_K     = 5'd10;
  localparam logic [4:0] KEY_L     = 5'd11;
  localparam logic [4:0] KEY_M     = 5'd12;
  localparam logic [4:0] KEY_N     = 5'd13;
  localparam logic [4:0] KEY_O     = 5'd14;
  localparam logic [4:0] KEY_P     = 5'd15;
  localparam logic [4:0] KEY_Q     = 5'd16;
  localparam logic [4:0] KEY_R     = 5'd17;
  localparam logic [4:0] KEY_S     = 5'd18;
  localparam logic [4:0] KEY_T     = 5'd19;
  localparam logic [4:0] KEY_U     = 5'd20;
  localparam logic [4:0] KEY_V     = 5'd21;
  localparam logic [4:0] KEY_W     = 5'd22;
  localparam logic [4:0] KEY_X     = 5'd23;
  localparam logic [4:0] KEY_Y     = 5'd24;
  localparam logic [4:0] KEY_Z     = 5'd25;
  localparam logic [4:0] KEY_OTHER = 5'b11101;
  localparam logic [4:0] KEY_ENTR  = 5'b11111;

  // Set-2 make codes
  localparam logic [7:0] SCAN_A    = 8'h1C;
  localparam logic [7:0] SCAN_B    = 8'h32;
  localparam logic [7:0] SCAN_C    = 8'h21;
  localparam logic [7:0] SCAN_D    = 8'h23;
  localparam logic [7:0] SCAN_E    = 8'h24;
  localparam logic [7:0] SCAN_F    = 8'h2B;
  localparam logic [7:0] SCAN_G    = 8'h34;
  localparam logic [7:0] SCAN_H    = 8'h33;
  localparam logic [7:0] SCAN_I    = 8'h43;
  localparam logic [7:0] SCAN_J    = 8'h3B;
  localparam logic [7:0] SCAN_K    = 8'h42;
  localparam logic [7:0] SCAN_L    = 8'h4B;
  localparam logic [7:0] SCAN_M    = 8'h3A;
  localparam logic [7:0] SCAN_N    = 8'h31;
  localparam logic [7:0] SCAN_O    = 8'h44;
  localparam logic [7:0] SCAN_P    = 8'h4D;
  localparam logic [7:0] SCAN_Q    = 8'h15;
  localparam logic [7:0] SCAN_R    = 8'h2D;
  localparam logic [7:0] SCAN_S    = 8'h1B;
  localparam logic [7:0] SCAN_T    = 8'h2C;
  localparam logic [7:0] SCAN_U    = 8'h3C;
  localparam logic [7:0] SCAN_V    = 8'h2A;
  localparam logic [7:0] SCAN_W    = 8'h1D;
  localparam logic [7:0] SCAN_X    = 8'h22;
  localparam logic [7:0] SCAN_Y    = 8'h35;
  localparam logic [7:0] SCAN_Z    = 8'h1A;
  localparam logic [7:0] SCAN_ENTR = 8'h5A;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_BIT = 2'd1,
    GAP      = 2'd2
  } tx_state_e;

  // Line value for bit idx of an 11-bit frame: start, data LSB first, odd parity, stop
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    v = 1'b1;
    if (idx == 4'd0) begin
      v = 1'b0;
    end else if (idx <= 4'd8) begin
      v = b[3'(idx - 4'd1)];
    end else if (idx == 4'd9) begin
      v = ~^b;
    end
    return v;
  endfunction

endpackage

// File: rtl/keycode_encoder_lut.sv
// Combinational letter-code to scan-code map, the inverse of the decoder table.
//   code_i      : 5-bit letter code
//   supported_o : 1 when code_i has a scan code (a..z, ENTR)
//   scan_o      : make byte, 0 when unsupported
module keycode_encoder_lut
  import ps2_keystroke_tx_pkg::*;
(
  input  logic [4:0] code_i,
  output logic       supported_o,
  output logic [7:0] scan_o
);

  always_comb begin
    supported_o = 1'b1;
    scan_o      = 8'h00;
    case (code_i)
      KEY_A:    scan_o = SCAN_A;
      KEY_B:    scan_o = SCAN_B;
      KEY_C:    scan_o = SCAN_C;
      KEY_D:    scan_o = SCAN_D;
      KEY_E:    scan_o = SCAN_E;
      KEY_F:    scan_o = SCAN_F;
      KEY_G:    scan_o = SCAN_G;
      KEY_H:    scan_o = SCAN_H;
      KEY_I:    scan_o = SCAN_I;
      KEY_J:    scan_o = SCAN_J;
      KEY_K:    scan_o = SCAN_K;
      KEY_L:    scan_o = SCAN_L;
      KEY_M:    scan_o = SCAN_M;
      KEY_N:    scan_o = SCAN_N;
      KEY_O:    scan_o = SCAN_O;
      KEY_P:    scan_o = SCAN_P;
      KEY_Q:    scan_o = SCAN_Q;
      KEY_R:    scan_o = SCAN_R;
      KEY_S:    scan_o = SCAN_S;
      KEY_T:    scan_o = SCAN_T;
      KEY_U:    scan_o = SCAN_U;
      KEY_V:    scan_o = SCAN_V;
      KEY_W:    scan_o = SCAN_W;
      KEY_X:    scan_o = SCAN_X;
      KEY_Y:    scan_o = SCAN_Y;
      KEY_Z:    scan_o = SCAN_Z;
      KEY_ENTR: scan_o = SCAN_ENTR;
      KEY_OTHER: supported_o = 1'b0;
      default:   supported_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keystroke_tx.sv
// PS/2 keyboard emulator: sends {make, F0, make} for an accepted letter code as
// three 11-bit device-to-host frames on idle-high clock/data lines.
//   clk, rst     : system clock, asynchronous active-high reset
//   code_in      : letter code, sampled on a code_valid && code_ready edge
//   code_valid   : send request
//   code_ready   : 1 when a request can be accepted
//   ps2_clk_out  : emulated PS/2 clock (registered)
//   ps2_data_out : emulated PS/2 data (registered)
//   code_err     : one-cycle pulse when an unsupported code is rejected
module ps2_keystroke_tx
  import ps2_keystroke_tx_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 5000,
  parameter int unsigned GAP_CYCLES  = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  output logic       code_err
);

  localparam int unsigned HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST  = 4'd10;
  localparam logic [1:0]       BYTE_LAST = 2'd2;

  tx_state_e        state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             phase_q, phase_d;  // 0: clock-high half, 1: clock-low half
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [7:0]       make_q, make_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             ps2_clk_q, ps2_clk_d;
  logic             ps2_data_q, ps2_data_d;
  logic [7:0]       tx_byte;
  logic             lut_supported;
  logic [7:0]       lut_scan;

  keycode_encoder_lut u_lut (
    .code_i      (code_in),
    .supported_o (lut_supported),
    .scan_o      (lut_scan)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hp_q       <= '0;
      gap_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      byte_q     <= '0;
      make_q     <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      gap_q      <= gap_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      make_q     <= make_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
    end
  end

  // Next-state, request handling and next line values
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    make_d  = make_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: ;
      SEND_BIT: begin
        if (hp_q == HP_LAST) begin
          hp_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              gap_d   = '0;
              state_d = GAP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (byte_q == BYTE_LAST) begin
            byte_d  = '0;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = '0;
            phase_d = 1'b0;
            hp_d    = '0;
            state_d = SEND_BIT;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // ready_q is also high in the final gap cycle, so a request there starts
    // the next frame with no idle cycle in between
    if (ready_q && code_valid) begin
      if (lut_supported) begin
        make_d  = lut_scan;
        state_d = SEND_BIT;
        hp_d    = '0;
        gap_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        byte_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    ready_d    = (state_d == IDLE) ||
                 ((state_d == GAP) && (byte_d == BYTE_LAST) && (gap_d == GAP_LAST));
    tx_byte    = (byte_d == 2'd1) ? BREAK_PREFIX : make_d;
    ps2_clk_d  = (state_d == SEND_BIT) ? ~phase_d : 1'b1;
    ps2_data_d = (state_d == SEND_BIT) ? frame_bit(tx_byte, bit_d) : 1'b1;
  end

  assign code_ready   = ready_q;
  assign code_err     = err_q;
  assign ps2_clk_out  = ps2_clk_q;
  assign ps2_data_out = ps2_data_q;

endmodule

// File: tb/tb_ps2_keystroke_tx.sv
// Self-checking bench for ps2_keystroke_tx with short PS/2 timing.
module tb_ps2_keystroke_tx;

  localparam int unsigned HP      = 4;
  localparam int unsigned GAPC    = 8;
  localparam int unsigned BIT_CYC = 2 * HP;
  localparam int unsigned FRAME   = 22 * HP;
  localparam int unsigned TOTAL   = 3 * (FRAME + GAPC);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] code_in = 5'd0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic       ps2_clk_out;
  logic       ps2_data_out;
  logic       code_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;

  logic [7:0] sb_q[$];
  int         frames_rx = 0;
  logic [7:0] last_byte = 8'h00;
  logic [10:0] fr = '0;
  int          nb = 0;
  logic        prev_clk = 1'b1;
  logic [7:0]  exp_b;

  ps2_keystroke_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_data_out (ps2_data_out),
    .code_err     (code_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int c);
    case (c)
      0: return 8'h1C;  1: return 8'h32;  2: return 8'h21;  3: return 8'h23;
      4: return 8'h24;  5: return 8'h2B;  6: return 8'h34;  7: return 8'h33;
      8: return 8'h43;  9: return 8'h3B; 10: return 8'h42; 11: return 8'h4B;
     12: return 8'h3A; 13: return 8'h31; 14: return 8'h44; 15: return 8'h4D;
     16: return 8'h15; 17: return 8'h2D; 18: return 8'h1B; 19: return 8'h2C;
     20: return 8'h3C; 21: return 8'h2A; 22: return 8'h1D; 23: return 8'h22;
     24: return 8'h35; 25: return 8'h1A; 31: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  // Receive-side view: scan byte back to letter code
  function automatic int dec(input logic [7:0] s);
    if (s == 8'h5A) return 31;
    for (int i = 0; i < 26; i++) if (enc(i) == s) return i;
    return 29;
  endfunction

  function automatic logic [10:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic push3(input logic [7:0] b);
    sb_q.push_back(b);
    sb_q.push_back(8'hF0);
    sb_q.push_back(b);
  endtask

  // Jump to relative cycle c (cycle 1 is the one after the accepting edge)
  task automatic goto(input int unsigned c);
    while (cyc < t0 + c - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] c);
    code_in    = c;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic check_frame(input string tag, input int unsigned s, input logic [10:0] pat);
    for (int k = 0; k < 11; k++) begin
      goto(s + k * BIT_CYC);
      chk($sformatf("%s_b%0d_data_first", tag, k), 32'(ps2_data_out), 32'(pat[k]));
      chk($sformatf("%s_b%0d_clk_high", tag, k), 32'(ps2_clk_out), 32'd1);
      goto(s + k * BIT_CYC + HP - 1);
      chk($sformatf("%s_b%0d_clk_high_end", tag, k), 32'(ps2_clk_out), 32'd1);
      goto(s + k * BIT_CYC + HP);
      chk($sformatf("%s_b%0d_clk_low", tag, k), 32'(ps2_clk_out), 32'd0);
      chk($sformatf("%s_b%0d_data_low", tag, k), 32'(ps2_data_out), 32'(pat[k]));
      goto(s + k * BIT_CYC + BIT_CYC - 1);
      chk($sformatf("%s_b%0d_data_last", tag, k), 32'(ps2_data_out), 32'(pat[k]));
    end
  endtask

  // Host-side receiver: sample data on each PS/2 clock falling edge
  always @(negedge clk) begin
    if (rst) begin
      nb       = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk_out) begin
        fr[nb] = ps2_data_out;
        nb++;
        if (nb == 11) begin
          nb = 0;
          frames_rx++;
          last_byte = fr[8:1];
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL unexpected_frame: observed byte %0h expected no frame", fr[8:1]);
          end else begin
            exp_b = sb_q.pop_front();
            chk("frame_byte", 32'(fr[8:1]), 32'(exp_b));
            chk("start_bit", 32'(fr[0]), 32'd0);
            chk("odd_parity", 32'(^fr[9:1]), 32'd1);
            chk("stop_bit", 32'(fr[10]), 32'd1);
          end
        end
      end
      prev_clk = ps2_clk_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb;
    logic ok;

    // Reset values
    idle(3);
    chk("rst_ready", 32'(code_ready), 32'd1);
    chk("rst_clk", 32'(ps2_clk_out), 32'd1);
    chk("rst_data", 32'(ps2_data_out), 32'd1);
    chk("rst_err", 32'(code_err), 32'd0);
    rst = 1'b0;
    idle(2);

    // 'a': explicit frame-0 pattern and latency
    push3(enc(0));
    send(5'd0);
    chk("a_ready_drop", 32'(code_ready), 32'd0);
    check_frame("a_f0", 1, 11'b100_0011_1000);
    check_frame("a_f1", 1 + FRAME + GAPC, build_frame(8'hF0));
    goto(TOTAL - 1);
    chk("a_ready_before", 32'(code_ready), 32'd0);
    goto(TOTAL);
    chk("a_ready_back", 32'(code_ready), 32'd1);
    chk("a_sb_empty", 32'(sb_q.size()), 32'd0);
    idle(5);

    // ENTR: parity 1 and decoder round trip
    push3(8'h5A);
    send(5'd31);
    goto(1 + 9 * BIT_CYC);
    chk("entr_parity", 32'(ps2_data_out), 32'd1);
    goto(TOTAL);
    chk("entr_decode", 32'(dec(last_byte)), 32'd31);
    chk("entr_sb_empty", 32'(sb_q.size()), 32'd0);
    idle(5);

    // Unsupported codes 26..30
    for (int c = 26; c <= 30; c++) begin
      send(5'(c));
      chk($sformatf("unsup%0d_err", c), 32'(code_err), 32'd1);
      chk($sformatf("unsup%0d_ready", c), 32'(code_ready), 32'd1);
      goto(2);
      chk($sformatf("unsup%0d_err_gone", c), 32'(code_err), 32'd0);
      idle(2);
    end

    // OTHER: lines stay idle for 300 cycles
    fb = frames_rx;
    send(5'd29);
    ok = 1'b1;
    repeat (300) begin
      if (!ps2_clk_out || !ps2_data_out || !code_ready) ok = 1'b0;
      idle(1);
    end
    chk("other_idle_lines", 32'(ok), 32'd1);
    chk("other_no_frames", 32'(frames_rx - fb), 32'd0);

    // 'q' accepted, 'w' while busy ignored
    fb = frames_rx;
    push3(enc(16));
    send(5'd16);
    goto(50);
    code_in    = 5'd22;
    code_valid = 1'b1;
    goto(60);
    code_valid = 1'b0;
    goto(TOTAL);
    chk("q_ready_back", 32'(code_ready), 32'd1);
    idle(100);
    chk("q_frames", 32'(frames_rx - fb), 32'd3);
    chk("q_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset mid-frame, then clean 'z'
    push3(enc(2));
    send(5'd2);
    goto(40);
    rst = 1'b1;
    #1;
    chk("arst_clk", 32'(ps2_clk_out), 32'd1);
    chk("arst_data", 32'(ps2_data_out), 32'd1);
    chk("arst_ready", 32'(code_ready), 32'd1);
    idle(2);
    rst = 1'b0;
    sb_q.delete();
    fb = frames_rx;
    idle(10);
    chk("post_rst_lines", 32'({ps2_clk_out, ps2_data_out, code_ready}), 32'h7);
    push3(enc(25));
    send(5'd25);
    check_frame("z_f0", 1, build_frame(8'h1A));
    goto(TOTAL - 1);
    chk("z_ready_before", 32'(code_ready), 32'd0);
    goto(TOTAL);
    chk("z_ready_back", 32'(code_ready), 32'd1);
    chk("z_frames", 32'(frames_rx - fb), 32'd3);
    idle(5);

    // Back-to-back 'm' then 'n' on the ready edge
    push3(enc(12));
    send(5'd12);
    goto(TOTAL);
    chk("m_ready_back", 32'(code_ready), 32'd1);
    chk("m_gap_lines", 32'({ps2_clk_out, ps2_data_out}), 32'h3);
    push3(enc(13));
    send(5'd13);
    chk("n_ready_drop", 32'(code_ready), 32'd0);
    check_frame("n_f0", 1, build_frame(8'h31));
    goto(TOTAL);
    chk("n_ready_back", 32'(code_ready), 32'd1);
    idle(5);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
